// File: rtl/fpu_add_arbiter.sv
// Two-requester arbiter in front of one shared fp16 adder: accepts one operation
// at a time, alternates on ties, returns the sum (or a NaN on adder timeout).
module fpu_add_arbiter #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    output logic        resp0_valid,
    output logic [15:0] resp0_result,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        resp1_valid,
    output logic [15:0] resp1_result,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_valid_in,
    input  logic [15:0] add_result,
    input  logic        add_valid_out,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DATA_W  = 16;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] NAN_TMO  = 16'h7C01;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_tmo;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_add_a;
    logic [DATA_W-1:0]   r_add_b;
    logic                r_add_valid_in;
    logic                r_resp0_valid;
    logic                r_resp1_valid;
    logic [DATA_W-1:0]   r_resp0_result;
    logic [DATA_W-1:0]   r_resp1_result;
    logic                r_timeout_err;
    logic                r_busy;

    logic w_grant0;
    logic w_grant1;
    logic w_idle;
    logic w_acc0;
    logic w_acc1;

    // On a tie the requester that was not served last wins.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_idle   = rst_n && (r_state == S_IDLE);

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign w_acc0     = req0_valid && req0_ready;
    assign w_acc1     = req1_valid && req1_ready;

    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_valid_in = r_add_valid_in;
    assign resp0_valid  = r_resp0_valid;
    assign resp1_valid  = r_resp1_valid;
    assign resp0_result = r_resp0_result;
    assign resp1_result = r_resp1_result;
    assign timeout_err  = r_timeout_err;
    assign busy         = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_owner        <= 1'b0;
            r_tmo          <= 1'b0;
            r_cnt          <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_valid_in <= 1'b0;
            r_resp0_valid  <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_resp0_result <= '0;
            r_resp1_result <= '0;
            r_timeout_err  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_add_valid_in <= 1'b0;
            r_resp0_valid  <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_timeout_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_add_a        <= w_acc1 ? req1_a : req0_a;
                        r_add_b        <= w_acc1 ? req1_b : req0_b;
                        r_owner        <= w_acc1;
                        r_last_grant   <= w_acc1;
                        r_add_valid_in <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion arriving on the last allowed cycle still wins.
                    if (add_valid_out || (r_cnt == CNT_LAST)) begin
                        if (r_owner) r_resp1_result <= add_valid_out ? add_result : NAN_TMO;
                        else         r_resp0_result <= add_valid_out ? add_result : NAN_TMO;
                        r_tmo   <= !add_valid_out;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_resp0_valid <= !r_owner;
                    r_resp1_valid <= r_owner;
                    r_timeout_err <= r_tmo;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter with a 5-cycle table-driven adder model.
module tb_fpu_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp0_result, resp1_result;
    logic [15:0] add_a, add_b, add_result;
    logic        add_valid_in, add_valid_out;
    logic        busy, timeout_err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int avi_q[$];
    bit mon_en   = 1'b0;
    bit model_en = 1'b1;
    bit spur     = 1'b0;

    logic [4:0]  sr    = '0;
    logic [15:0] m_res = '0;

    always #5 clk = ~clk;

    fpu_add_arbiter #(.TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_result(resp0_result),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_result(resp1_result),
        .add_a(add_a), .add_b(add_b), .add_valid_in(add_valid_in),
        .add_result(add_result), .add_valid_out(add_valid_out),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Hand-computed binary16 sums for the operand pairs used below.
    function automatic logic [15:0] fp_sum(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C003C00: fp_sum = 16'h4000;
            32'h40003C00: fp_sum = 16'h4200;
            32'h42004200: fp_sum = 16'h4600;
            32'h44003C00: fp_sum = 16'h4500;
            default:      fp_sum = 16'hFFFF;
        endcase
    endfunction

    // Adder model: completion is seen at the 5th edge after the start pulse is sampled.
    always @(posedge clk) begin
        sr <= {sr[3:0], add_valid_in};
        if (add_valid_in) m_res <= fp_sum(add_a, add_b);
    end
    assign add_valid_out = (sr[4] & model_en) | spur;
    assign add_result    = m_res;

    always @(negedge clk) begin
        cyc++;
        if (mon_en && add_valid_in) avi_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_op(input bit port, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input bit exp_to, input int exp_lat);
        int lat;
        @(negedge clk);
        if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        chk("ready_own",   32'(port ? req1_ready : req0_ready), 32'(1));
        chk("ready_other", 32'(port ? req0_ready : req1_ready), 32'(0));
        @(negedge clk);
        lat = 1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("issue_pulse", 32'(add_valid_in), 32'(1));
        chk("add_a", 32'(add_a), 32'(a));
        chk("add_b", 32'(add_b), 32'(b));
        chk("busy_op", 32'(busy), 32'(1));
        @(negedge clk);
        lat++;
        chk("issue_once", 32'(add_valid_in), 32'(0));
        while (!(resp0_valid || resp1_valid) && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_port", 32'({resp1_valid, resp0_valid}), port ? 32'(2) : 32'(1));
        chk("result", 32'(port ? resp1_result : resp0_result), 32'(exp));
        chk("tmo_err", 32'(timeout_err), 32'(exp_to));
        chk("busy_at_resp", 32'(busy), 32'(0));
        @(negedge clk);
        chk("resp_1cyc", 32'({resp1_valid, resp0_valid, timeout_err}), 32'(0));
    endtask

    initial begin
        int w;
        int nresp;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", 32'({busy, add_valid_in, resp0_valid, resp1_valid, timeout_err,
                             req0_ready, req1_ready}), 32'(0));
        chk("rst_data", 32'({add_a, add_b} | {resp0_result, resp1_result}), 32'(0));

        // Tie arbitration straight out of reset: grants must go 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
        req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h3C00;
        #1;
        chk("first_ready", 32'({req1_ready, req0_ready}), 32'(1));
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (!(req0_ready || req1_ready) && w < 40) begin @(negedge clk); w++; end
            chk("tie_grant", 32'(req1_ready), 32'(i % 2));
            @(negedge clk);
            w = 0;
            while (!(resp0_valid || resp1_valid) && w < 40) begin @(negedge clk); w++; end
            chk("tie_port", 32'({resp1_valid, resp0_valid}), (i % 2) ? 32'(2) : 32'(1));
            chk("tie_result", 32'((i % 2) ? resp1_result : resp0_result),
                (i % 2) ? 32'h4200 : 32'h4000);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) @(negedge clk);

        do_op(1'b0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 8);

        // Adder never answers: NaN plus timeout_err, then normal service resumes.
        model_en = 1'b0;
        do_op(1'b1, 16'h4200, 16'h4200, 16'h7C01, 1'b1, 35);
        model_en = 1'b1;
        do_op(1'b0, 16'h4400, 16'h3C00, 16'h4500, 1'b0, 8);

        // Stray completion in IDLE is ignored.
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        nresp = 0;
        repeat (4) begin
            @(negedge clk);
            nresp += int'(resp0_valid) + int'(resp1_valid);
        end
        chk("spur_noresp", 32'(nresp), 32'(0));
        chk("spur_idle", 32'(busy), 32'(0));
        chk("spur_keep", 32'(resp0_result), 32'h4500);

        // Reset during WAIT, then the adder's late completion must not respond.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({busy, add_valid_in, resp0_valid, resp1_valid, timeout_err}), 32'(0));
        chk("mid_rst_data", 32'({add_a, add_b} | {resp0_result, resp1_result}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        nresp = 0;
        repeat (12) begin
            @(negedge clk);
            nresp += int'(resp0_valid) + int'(resp1_valid);
        end
        chk("late_noresp", 32'(nresp), 32'(0));
        chk("late_idle", 32'(busy), 32'(0));

        // Back-to-back on requester 1: issue pulses 8 cycles apart, one cycle wide.
        @(negedge clk);
        mon_en = 1'b1;
        req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h3C00;
        nresp = 0;
        w = 0;
        while (nresp < 3 && w < 60) begin
            @(negedge clk);
            w++;
            if (resp1_valid) begin
                nresp++;
                chk("b2b_result", 32'(resp1_result), 32'h4200);
            end
        end
        req1_valid = 1'b0;
        mon_en = 1'b0;
        chk("b2b_count", 32'(nresp), 32'(3));
        chk("b2b_issues", 32'(avi_q.size()), 32'(3));
        if (avi_q.size() >= 3) begin
            chk("b2b_gap0", 32'(avi_q[1] - avi_q[0]), 32'(8));
            chk("b2b_gap1", 32'(avi_q[2] - avi_q[1]), 32'(8));
        end
        repeat (2) @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
